rx_burst_gate: RTL and testbench

RX_BURST_GATE -- requirements
Module: rx_burst_gate

---
 rtl/rx_pkg.sv | 27 ++
 rtl/rx_bg_timer.sv | 36 +++
 rtl/rx_burst_gate.sv | 161 ++++++++++++++++
 tb/tb_rx_burst_gate.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared types for the RX burst gate: state encoding and arm/hang counter widths.
// The LOCKOUT state exists only when RX_BG_MAXLEN_EN is defined.
package rx_pkg;

   localparam int BG_ARM_W  = 8;
   localparam int BG_HANG_W = 8;
   localparam int BG_TMR_W  = (BG_ARM_W > BG_HANG_W) ? BG_ARM_W : BG_HANG_W;

   localparam logic [2:0] ST_IDLE_ENC    = 3'd0;
   localparam logic [2:0] ST_ARM_ENC     = 3'd1;
   localparam logic [2:0] ST_ACTIVE_ENC  = 3'd2;
   localparam logic [2:0] ST_HANG_ENC    = 3'd3;
   localparam logic [2:0] ST_LOCKOUT_ENC = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE_ENC,
      S_ARM     = ST_ARM_ENC,
      S_ACTIVE  = ST_ACTIVE_ENC,
`ifdef RX_BG_MAXLEN_EN
      S_HANG    = ST_HANG_ENC,
      S_LOCKOUT = ST_LOCKOUT_ENC
`else
      S_HANG    = ST_HANG_ENC
`endif
   } bg_state_e;

endpackage

// File: rtl/rx_bg_timer.sv
// Saturating phase counter shared by the arm and hang phases.
// load restarts at 1, step advances; expire flags that the new count reaches limit.
module rx_bg_timer
   import rx_pkg::*;
#(
   parameter int W = BG_TMR_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic         step,
   input  logic [W-1:0] limit,
   output logic         expire
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load)
         count_d = W'(1);
      else if (step && (count_q != '1))
         count_d = count_q + W'(1);
      // limits of 0 and 1 both expire on the loading cycle
      expire = (load || step) && (count_d >= limit);
   end

   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else if (en)
         count_q <= count_d;
   end

endmodule

// File: rtl/rx_burst_gate.sv
// Burst gate: opens on a sustained SD_flag, forwards I/Q while open, closes after a hang period.
// Optional macro RX_BG_MAXLEN_EN adds a forced close at RX_BG_MAXLEN samples plus a LOCKOUT state.
module rx_burst_gate
   import rx_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int LEN_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clk_enable,
   input  logic [BG_ARM_W-1:0]         RX_BG_ARM,
   input  logic [BG_HANG_W-1:0]        RX_BG_HANG,
   input  logic [LEN_WIDTH-1:0]        RX_BG_MAXLEN,
   input  logic                        SD_flag,
   input  logic signed [WIDTH-1:0]     I_tdata,
   input  logic                        I_tvalid,
   input  logic signed [WIDTH-1:0]     Q_tdata,
   input  logic                        Q_tvalid,
   output logic signed [WIDTH-1:0]     I_out_tdata,
   output logic signed [WIDTH-1:0]     Q_out_tdata,
   output logic                        out_tvalid,
   output logic                        burst_active,
   output logic                        burst_start,
   output logic                        burst_end,
   output logic [LEN_WIDTH-1:0]        burst_len
);

   bg_state_e               state_q, state_d;
   logic signed [WIDTH-1:0] i_q, i_d, q_q, q_d;
   logic                    vld_q, vld_d;
   logic                    start_q, start_d;
   logic                    end_q, end_d;
   logic [LEN_WIDTH-1:0]    len_q, len_d;

   logic                    open_st;
   logic                    tmr_load, tmr_step, tmr_expire;
   logic [BG_TMR_W-1:0]     tmr_limit;

   assign open_st   = (state_q == S_ACTIVE) || (state_q == S_HANG);
   assign tmr_limit = open_st ? BG_TMR_W'(RX_BG_HANG) : BG_TMR_W'(RX_BG_ARM);

   // Timer controls depend only on state and SD_flag, keeping expire free of loops.
   always_comb begin
      tmr_load = 1'b0;
      tmr_step = 1'b0;
      case (state_q)
         S_IDLE:   tmr_load = SD_flag;
         S_ARM:    tmr_step = SD_flag;
         S_ACTIVE: tmr_load = !SD_flag;
         S_HANG:   tmr_step = !SD_flag;
         default:  ;
      endcase
   end

   rx_bg_timer #(.W(BG_TMR_W)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .en     (clk_enable),
      .load   (tmr_load),
      .step   (tmr_step),
      .limit  (tmr_limit),
      .expire (tmr_expire)
   );

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      q_d     = q_q;
      len_d   = len_q;
      vld_d   = 1'b0;
      start_d = 1'b0;
      end_d   = 1'b0;

      if (clk_enable) begin
         if (open_st && I_tvalid && Q_tvalid) begin
            i_d   = I_tdata;
            q_d   = Q_tdata;
            vld_d = 1'b1;
            if (len_q != '1)
               len_d = len_q + LEN_WIDTH'(1);
         end

         case (state_q)
            S_IDLE:
               if (SD_flag)
                  state_d = tmr_expire ? S_ACTIVE : S_ARM;
            S_ARM:
               if (!SD_flag)
                  state_d = S_IDLE;
               else if (tmr_expire)
                  state_d = S_ACTIVE;
            S_ACTIVE:
               if (!SD_flag)
                  state_d = tmr_expire ? S_IDLE : S_HANG;
            S_HANG:
               // a returning SD_flag beats a hang expiry
               if (SD_flag)
                  state_d = S_ACTIVE;
               else if (tmr_expire)
                  state_d = S_IDLE;
`ifdef RX_BG_MAXLEN_EN
            S_LOCKOUT:
               if (!SD_flag)
                  state_d = S_IDLE;
`endif
            default:
               state_d = S_IDLE;
         endcase

         if (!open_st && (state_d == S_ACTIVE)) begin
            start_d = 1'b1;
            len_d   = '0;
         end
         if (open_st && (state_d == S_IDLE))
            end_d = 1'b1;

`ifdef RX_BG_MAXLEN_EN
         // Forced close; a simultaneous hang expiry (SD low) still lands in IDLE.
         if (open_st && (RX_BG_MAXLEN != '0) && (len_d >= RX_BG_MAXLEN)) begin
            end_d   = 1'b1;
            state_d = (state_d == S_IDLE) ? S_IDLE : S_LOCKOUT;
         end
`endif
      end
   end

`ifndef RX_BG_MAXLEN_EN
   logic unused_maxlen;
   assign unused_maxlen = ^RX_BG_MAXLEN;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         q_q     <= '0;
         vld_q   <= 1'b0;
         start_q <= 1'b0;
         end_q   <= 1'b0;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         q_q     <= q_d;
         vld_q   <= vld_d;
         start_q <= start_d;
         end_q   <= end_d;
         len_q   <= len_d;
      end
   end

   assign I_out_tdata  = i_q;
   assign Q_out_tdata  = q_q;
   assign out_tvalid   = vld_q;
   assign burst_active = open_st;
   assign burst_start  = start_q;
   assign burst_end    = end_q;
   assign burst_len    = len_q;

endmodule

// File: tb/tb_rx_burst_gate.sv
// Self-checking bench for rx_burst_gate: directed scenarios plus randomized traffic
// against a run-length reference model.
module tb_rx_burst_gate;

   localparam int W       = 16;
   localparam int LW      = 6;
   localparam int LEN_MAX = (1 << LW) - 1;
`ifdef RX_BG_MAXLEN_EN
   localparam bit MLEN_ON = 1'b1;
`else
   localparam bit MLEN_ON = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst, ce, sd, iv, qv;
   logic [7:0]          arm, hang;
   logic [LW-1:0]       maxlen;
   logic signed [W-1:0] id, qd, io, qo;
   logic                ov, act, bs, be;
   logic [LW-1:0]       blen;

   always #5 clk = ~clk;

   rx_burst_gate #(.WIDTH(W), .LEN_WIDTH(LW)) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_enable   (ce),
      .RX_BG_ARM    (arm),
      .RX_BG_HANG   (hang),
      .RX_BG_MAXLEN (maxlen),
      .SD_flag      (sd),
      .I_tdata      (id),
      .I_tvalid     (iv),
      .Q_tdata      (qd),
      .Q_tvalid     (qv),
      .I_out_tdata  (io),
      .Q_out_tdata  (qo),
      .out_tvalid   (ov),
      .burst_active (act),
      .burst_start  (bs),
      .burst_end    (be),
      .burst_len    (blen)
   );

   int errs   = 0;
   int checks = 0;
   int n_start, n_end, n_vld;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference model: counts consecutive high/low SD runs rather than tracking states.
   bit                  m_open, m_lock;
   int                  hi_run, lo_run;
   logic                e_vld, e_start, e_end;
   int                  e_len;
   logic signed [W-1:0] e_i, e_q;

   function automatic int atleast1(input int v);
      return (v < 1) ? 1 : v;
   endfunction

   task automatic model_tick();
      bit closing, maxhit;
      if (rst) begin
         m_open = 0; m_lock = 0; hi_run = 0; lo_run = 0;
         e_vld = 0; e_start = 0; e_end = 0; e_len = 0; e_i = '0; e_q = '0;
      end else begin
         e_vld = 0; e_start = 0; e_end = 0;
         if (ce) begin
            if (m_lock) begin
               if (!sd) m_lock = 0;
            end else if (!m_open) begin
               hi_run = sd ? hi_run + 1 : 0;
               if (hi_run >= atleast1(int'(arm))) begin
                  m_open = 1; hi_run = 0; lo_run = 0; e_start = 1; e_len = 0;
               end
            end else begin
               if (iv && qv) begin
                  e_vld = 1; e_i = id; e_q = qd;
                  if (e_len < LEN_MAX) e_len++;
               end
               lo_run  = sd ? 0 : lo_run + 1;
               closing = (lo_run >= atleast1(int'(hang)));
               maxhit  = MLEN_ON && (maxlen != 0) && (e_len >= int'(maxlen));
               if (closing || maxhit) begin
                  m_open = 0; e_end = 1; lo_run = 0; hi_run = 0;
                  if (!closing) m_lock = 1;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("burst_active", 64'(act), 64'(m_open));
      chk("burst_start", 64'(bs), 64'(e_start));
      chk("burst_end", 64'(be), 64'(e_end));
      chk("out_tvalid", 64'(ov), 64'(e_vld));
      chk("burst_len", 64'(blen), 64'(e_len));
      chk("I_out_tdata", 64'(io), 64'(e_i));
      chk("Q_out_tdata", 64'(qo), 64'(e_q));
   endtask

   task automatic cyc(input bit s, input bit e = 1'b1, input bit v = 1'b1);
      sd = s; ce = e; iv = v; qv = v;
      id = W'($urandom); qd = W'($urandom);
      @(posedge clk);
      model_tick();
      @(negedge clk);
      compare_all();
      if (bs) n_start++;
      if (be) n_end++;
      if (ov) n_vld++;
   endtask

   task automatic run(input bit s, input int n);
      for (int k = 0; k < n; k++) cyc(s);
   endtask

   task automatic clr_counts();
      n_start = 0; n_end = 0; n_vld = 0;
   endtask

   initial begin
      bit sd_r;
      rst = 1'b1; ce = 1'b1; sd = 1'b0; iv = 1'b0; qv = 1'b0;
      id = '0; qd = '0; arm = 8'd4; hang = 8'd3; maxlen = '0;
      clr_counts();
      cyc(1'b0); cyc(1'b0);
      rst = 1'b0;

      // short SD pulse never opens
      clr_counts();
      run(1'b1, 3); run(1'b0, 10);
      chk("short_pulse_starts", 64'(n_start), 64'd0);
      chk("short_pulse_vld", 64'(n_vld), 64'd0);

      // basic burst: 20 high then low
      clr_counts();
      run(1'b1, 20); run(1'b0, 6);
      chk("basic_starts", 64'(n_start), 64'd1);
      chk("basic_ends", 64'(n_end), 64'd1);
      chk("basic_len", 64'(blen), 64'd19);

      // hang bridged by SD returning
      clr_counts();
      run(1'b1, 6); run(1'b0, 2); run(1'b1, 5); run(1'b0, 5);
      chk("bridge_starts", 64'(n_start), 64'd1);
      chk("bridge_ends", 64'(n_end), 64'd1);

      // clk_enable toggling while active
      run(1'b1, 6);
      clr_counts();
      for (int k = 0; k < 20; k++) cyc(1'b1, (k % 2) == 0);
      chk("ce_toggle_vld", 64'(n_vld), 64'd10);
      run(1'b0, 5);

      // reset in ACTIVE aborts silently
      run(1'b1, 6);
      clr_counts();
      rst = 1'b1; cyc(1'b1); rst = 1'b0;
      chk("rst_active", 64'(act), 64'd0);
      chk("rst_len", 64'(blen), 64'd0);
      run(1'b0, 6);
      chk("rst_no_end", 64'(n_end), 64'd0);

      // zero arm/hang boundaries
      arm = 8'd0; hang = 8'd0;
      clr_counts();
      run(1'b1, 4); run(1'b0, 2);
      chk("zero_cfg_starts", 64'(n_start), 64'd1);
      chk("zero_cfg_len", 64'(blen), 64'd4);

      // burst_len saturation
      arm = 8'd1; hang = 8'd2;
      run(1'b1, 70); run(1'b0, 3);
      chk("len_saturate", 64'(blen), 64'(LEN_MAX));

`ifdef RX_BG_MAXLEN_EN
      arm = 8'd2; hang = 8'd3; maxlen = LW'(8);
      clr_counts();
      run(1'b1, 20);
      chk("maxlen_len", 64'(blen), 64'd8);
      chk("maxlen_ends", 64'(n_end), 64'd1);
      run(1'b0, 1); run(1'b1, 4);
      chk("maxlen_rearm", 64'(n_start), 64'd2);
      run(1'b0, 5);
`endif

      // randomized traffic
      sd_r = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if ((k % 400) == 0) begin
            arm    = 8'($urandom_range(0, 5));
            hang   = 8'($urandom_range(0, 4));
            maxlen = LW'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 4) == 0) sd_r = ~sd_r;
         rst = ($urandom_range(0, 299) == 0);
         cyc(sd_r, $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0);
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
